tl_frag_arbiter: RTL and testbench
==================================

# tl_frag_arbiter

Two-port round-robin TileLink-UL arbiter that shares one fragmenter input port (32-bit data, 17-bit address, 5-bit source, 3-bit size) between two requesters. It tags each request with the port index in the source MSB and locks the grant for multi-beat Put messages. D responses are routed back by that tag. Per-port in-flight counters throttle each requester and drive quiesce/error status. It sits directly upstream of the fragmenter's `auto_in` A/D channels.

## Interface
- MAX_INFLIGHT, 15: per-port outstanding-message limit; counter width is 4 bits.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- inN_a_valid / inN_a_ready  in / out  1  requester N (N=0,1) A handshake.
- inN_a_bits_opcode, _param, _size  in  3 each  TileLink A fields.
- inN_a_bits_source  in  4  requester source ID.
- inN_a_bits_address  in  17  byte address.
- inN_a_bits_mask  in  4  byte-lane mask.
- inN_a_bits_data  in  32  write data.
- inN_a_bits_corrupt  in  1  corrupt flag.
- out_a_valid / out_a_ready  out / in  1  A handshake toward the fragmenter.
- out_a_bits_opcode, _param, _size  out  3 each  muxed A fields.
- out_a_bits_source  out  5  `{port, inN_a_bits_source}`.
- out_a_bits_address  out  17  muxed A field.
- out_a_bits_mask  out  4  muxed A field.
- out_a_bits_data  out  32  muxed A field.
- out_a_bits_corrupt  out  1  muxed A field.
- out_d_valid / out_d_ready  in / out  1  D handshake from the fragmenter.
- out_d_bits_opcode, _size  in  3 each  D fields.
- out_d_bits_source  in  5  bit 4 selects the destination port.
- out_d_bits_data  in  32  D data.
- inN_d_valid / inN_d_ready  out / in  1  D handshake to requester N.
- inN_d_bits_opcode, _size  out  3 each  D fields.
- inN_d_bits_source  out  4  `out_d_bits_source[3:0]`.
- inN_d_bits_data  out  32  D data.
- idle  out  1  high when no lock is held and both in-flight counters are 0.
- error  out  1  sticky flag for an unexpected D beat.

## Operation
- Beats per A message: 1 when opcode[2]=1 (Get) or size≤2. Otherwise 2^(size-2), up to 32 beats at size 7.
- Beat counter: 5 bits.
- Eligibility: port N is eligible when inN_a_valid=1 and cnt[N]<MAX_INFLIGHT. An unlocked port at the limit is masked.
- Arbitration, when unlocked:
  - If only one port is eligible, it wins.
  - If both are eligible, the port named by the rr pointer wins.
- The grant is combinational. out_a_valid = the winner's valid. inN_a_ready = out_a_ready & (N is the winner); it is 0 for the loser.
- First beat fire of a message:
  - cnt[winner] += 1.
  - rr pointer := the other port.
  - If the message has more than one beat: lock := 1, lock_port := winner, beats_left := beats-1.
- Locked:
  - Only lock_port is selected, regardless of its counter.
  - Each fire decrements beats_left. The fire with beats_left=1 clears lock.
  - The other port sees ready=0 throughout.
- D routing: port p = out_d_bits_source[4]. inp_d_valid = out_d_valid, out_d_ready = inp_d_ready, and the other port's d_valid is 0.
- D beats per message: opcode=1 (AccessAckData) uses the size rule above; all other opcodes are 1 beat.
- D tracking: a per-port beat counter (5 bits) tracks D beats. On the last D beat fire, cnt[p] -= 1.
- Same-cycle events: a first A fire and a last D fire on the same port leave cnt unchanged.
- error: set when a D first beat fires for a port whose cnt is 0 and which has no same-cycle A first fire. The counter stays at 0 (no underflow). error clears only on reset.

## Timing
- A and D paths are zero-latency combinational passthrough; no registers on data.
- Reset (asynchronous assert, release synchronous to clock): lock=0, beats_left=0, rr=0 (port 0 preferred), cnt[0..1]=0, D beat counters=0, error=0.
- Output values while reset is asserted:
  - idle=1, error=0.
  - out_a_valid, inN_a_ready, inN_d_valid and out_d_ready follow only their combinational inputs; lock=0.
- Reset mid-burst: the lock and all counters drop immediately. Arbitration restarts with port 0 preferred.
- The winner may change while out_a_valid=1 and out_a_ready=0 before a first-beat fire; downstream tolerates this (TL-UL).

## Test plan
- Single Get on port 0, source 3, address 0x100, size 2. Required: out_a source 0x03, 1 cycle, cnt0=1. D AccessAckData source 0x03 appears on in0_d; afterwards cnt0=0 and idle=1.
- Both ports hold Get continuously. Required: grants alternate 0,1,0,1 and sources alternate bit 4.
- Port 1 PutFull size 4 (4 beats) while port 0 is valid. Required: port 1 holds all 4 beats and in0_a_ready=0 throughout; port 0 wins on the next cycle.
- Port 0 issues 15 outstanding Gets with D stalled. Required: the 16th request is masked and port 1 still gets grants. One D response re-enables port 0.
- D beat with source 0x12 while cnt1=0. Required: error=1 and sticky; cnt1 stays 0.
- Assert reset during beat 2 of an 8-beat Put. Required: after release, lock=0, idle=1, and the next grant goes to port 0.

Source files
------------

// File: rtl/tl_frag_arbiter_if.sv
// TileLink-UL A/D channels seen by the two-port fragmenter arbiter: two requester
// ports on one side and the shared fragmenter input port on the other.
interface tl_frag_arbiter_if;
    logic        in0_a_valid, in0_a_ready;
    logic [2:0]  in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
    logic [3:0]  in0_a_bits_source;
    logic [16:0] in0_a_bits_address;
    logic [3:0]  in0_a_bits_mask;
    logic [31:0] in0_a_bits_data;
    logic        in0_a_bits_corrupt;

    logic        in1_a_valid, in1_a_ready;
    logic [2:0]  in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
    logic [3:0]  in1_a_bits_source;
    logic [16:0] in1_a_bits_address;
    logic [3:0]  in1_a_bits_mask;
    logic [31:0] in1_a_bits_data;
    logic        in1_a_bits_corrupt;

    logic        out_a_valid, out_a_ready;
    logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
    logic [4:0]  out_a_bits_source;
    logic [16:0] out_a_bits_address;
    logic [3:0]  out_a_bits_mask;
    logic [31:0] out_a_bits_data;
    logic        out_a_bits_corrupt;

    logic        out_d_valid, out_d_ready;
    logic [2:0]  out_d_bits_opcode, out_d_bits_size;
    logic [4:0]  out_d_bits_source;
    logic [31:0] out_d_bits_data;

    logic        in0_d_valid, in0_d_ready;
    logic [2:0]  in0_d_bits_opcode, in0_d_bits_size;
    logic [3:0]  in0_d_bits_source;
    logic [31:0] in0_d_bits_data;

    logic        in1_d_valid, in1_d_ready;
    logic [2:0]  in1_d_bits_opcode, in1_d_bits_size;
    logic [3:0]  in1_d_bits_source;
    logic [31:0] in1_d_bits_data;

    // Arbiter view.
    modport slave (
        input  in0_a_valid, in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size,
               in0_a_bits_source, in0_a_bits_address, in0_a_bits_mask, in0_a_bits_data,
               in0_a_bits_corrupt,
        input  in1_a_valid, in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size,
               in1_a_bits_source, in1_a_bits_address, in1_a_bits_mask, in1_a_bits_data,
               in1_a_bits_corrupt,
        output in0_a_ready, in1_a_ready,
        output out_a_valid, out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
               out_a_bits_source, out_a_bits_address, out_a_bits_mask, out_a_bits_data,
               out_a_bits_corrupt,
        input  out_a_ready,
        input  out_d_valid, out_d_bits_opcode, out_d_bits_size, out_d_bits_source,
               out_d_bits_data,
        output out_d_ready,
        output in0_d_valid, in0_d_bits_opcode, in0_d_bits_size, in0_d_bits_source,
               in0_d_bits_data,
        output in1_d_valid, in1_d_bits_opcode, in1_d_bits_size, in1_d_bits_source,
               in1_d_bits_data,
        input  in0_d_ready, in1_d_ready
    );

    // Requester/fragmenter environment view.
    modport master (
        output in0_a_valid, in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size,
               in0_a_bits_source, in0_a_bits_address, in0_a_bits_mask, in0_a_bits_data,
               in0_a_bits_corrupt,
        output in1_a_valid, in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size,
               in1_a_bits_source, in1_a_bits_address, in1_a_bits_mask, in1_a_bits_data,
               in1_a_bits_corrupt,
        input  in0_a_ready, in1_a_ready,
        input  out_a_valid, out_a_bits_opcode, out_a_bits_param, out_a_bits_size,
               out_a_bits_source, out_a_bits_address, out_a_bits_mask, out_a_bits_data,
               out_a_bits_corrupt,
        output out_a_ready,
        output out_d_valid, out_d_bits_opcode, out_d_bits_size, out_d_bits_source,
               out_d_bits_data,
        input  out_d_ready,
        input  in0_d_valid, in0_d_bits_opcode, in0_d_bits_size, in0_d_bits_source,
               in0_d_bits_data,
        input  in1_d_valid, in1_d_bits_opcode, in1_d_bits_size, in1_d_bits_source,
               in1_d_bits_data,
        output in0_d_ready, in1_d_ready
    );
endinterface

// File: rtl/tl_frag_arbiter.sv
// Two-port round-robin TL-UL arbiter in front of the fragmenter: tags A requests with
// the port index in source[4], locks multi-beat Puts, routes D back by that tag.
module tl_frag_arbiter #(
    parameter int MAX_INFLIGHT = 15
) (
    input  logic             clock,
    input  logic             reset,
    tl_frag_arbiter_if.slave bus,
    output logic             idle,
    output logic             error
);
    localparam logic [3:0] CNT_MAX = 4'(MAX_INFLIGHT);

    // Beats minus one of a message whose opcode carries data at this size.
    function automatic logic [4:0] f_extra_beats(input logic [2:0] size);
        if (size <= 3'd2) return 5'd0;
        return 5'((6'd1 << (size - 3'd2)) - 6'd1);
    endfunction

    logic [1:0]       w_a_valid;
    logic [1:0][2:0]  w_a_opcode, w_a_param, w_a_size;
    logic [1:0][3:0]  w_a_source, w_a_mask;
    logic [1:0][16:0] w_a_address;
    logic [1:0][31:0] w_a_data;
    logic [1:0]       w_a_corrupt;

    assign w_a_valid   = {bus.in1_a_valid, bus.in0_a_valid};
    assign w_a_opcode  = {bus.in1_a_bits_opcode, bus.in0_a_bits_opcode};
    assign w_a_param   = {bus.in1_a_bits_param, bus.in0_a_bits_param};
    assign w_a_size    = {bus.in1_a_bits_size, bus.in0_a_bits_size};
    assign w_a_source  = {bus.in1_a_bits_source, bus.in0_a_bits_source};
    assign w_a_address = {bus.in1_a_bits_address, bus.in0_a_bits_address};
    assign w_a_mask    = {bus.in1_a_bits_mask, bus.in0_a_bits_mask};
    assign w_a_data    = {bus.in1_a_bits_data, bus.in0_a_bits_data};
    assign w_a_corrupt = {bus.in1_a_bits_corrupt, bus.in0_a_bits_corrupt};

    logic            r_lock, r_lock_port, r_rr, r_error;
    logic [4:0]      r_beats_left;
    logic [1:0][3:0] r_cnt;
    logic [1:0][4:0] r_dleft;

    logic [1:0] w_elig;
    logic       w_sel, w_any;

    // While locked the counter limit is ignored: the burst must complete.
    always_comb begin
        w_elig[0] = w_a_valid[0] && (r_cnt[0] < CNT_MAX);
        w_elig[1] = w_a_valid[1] && (r_cnt[1] < CNT_MAX);
        w_sel     = 1'b0;
        w_any     = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_port;
            w_any = w_a_valid[r_lock_port];
        end else if (w_elig[0] && w_elig[1]) begin
            w_sel = r_rr;
            w_any = 1'b1;
        end else if (w_elig[1]) begin
            w_sel = 1'b1;
            w_any = 1'b1;
        end else if (w_elig[0]) begin
            w_any = 1'b1;
        end
    end

    assign bus.out_a_valid        = w_any;
    assign bus.in0_a_ready        = bus.out_a_ready & w_any & ~w_sel;
    assign bus.in1_a_ready        = bus.out_a_ready & w_any & w_sel;
    assign bus.out_a_bits_opcode  = w_a_opcode[w_sel];
    assign bus.out_a_bits_param   = w_a_param[w_sel];
    assign bus.out_a_bits_size    = w_a_size[w_sel];
    assign bus.out_a_bits_source  = {w_sel, w_a_source[w_sel]};
    assign bus.out_a_bits_address = w_a_address[w_sel];
    assign bus.out_a_bits_mask    = w_a_mask[w_sel];
    assign bus.out_a_bits_data    = w_a_data[w_sel];
    assign bus.out_a_bits_corrupt = w_a_corrupt[w_sel];

    logic w_d_port;
    assign w_d_port              = bus.out_d_bits_source[4];
    assign bus.out_d_ready       = w_d_port ? bus.in1_d_ready : bus.in0_d_ready;
    assign bus.in0_d_valid       = bus.out_d_valid & ~w_d_port;
    assign bus.in1_d_valid       = bus.out_d_valid & w_d_port;
    assign bus.in0_d_bits_opcode = bus.out_d_bits_opcode;
    assign bus.in1_d_bits_opcode = bus.out_d_bits_opcode;
    assign bus.in0_d_bits_size   = bus.out_d_bits_size;
    assign bus.in1_d_bits_size   = bus.out_d_bits_size;
    assign bus.in0_d_bits_source = bus.out_d_bits_source[3:0];
    assign bus.in1_d_bits_source = bus.out_d_bits_source[3:0];
    assign bus.in0_d_bits_data   = bus.out_d_bits_data;
    assign bus.in1_d_bits_data   = bus.out_d_bits_data;

    logic       w_a_fire, w_a_first, w_d_fire, w_d_first, w_d_last;
    logic [4:0] w_a_extra, w_d_extra;
    logic [1:0] w_inc, w_dec;

    assign w_a_fire  = w_any & bus.out_a_ready;
    assign w_a_first = w_a_fire & ~r_lock;
    assign w_a_extra = w_a_opcode[w_sel][2] ? 5'd0 : f_extra_beats(w_a_size[w_sel]);
    assign w_d_fire  = bus.out_d_valid & bus.out_d_ready;
    assign w_d_extra = (bus.out_d_bits_opcode == 3'd1) ? f_extra_beats(bus.out_d_bits_size) : 5'd0;
    assign w_d_first = (r_dleft[w_d_port] == 5'd0);
    assign w_d_last  = w_d_first ? (w_d_extra == 5'd0) : (r_dleft[w_d_port] == 5'd1);
    assign w_inc     = {w_a_first & w_sel, w_a_first & ~w_sel};
    assign w_dec     = {w_d_fire & w_d_last & w_d_port, w_d_fire & w_d_last & ~w_d_port};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lock       <= 1'b0;
            r_lock_port  <= 1'b0;
            r_beats_left <= 5'd0;
            r_rr         <= 1'b0;
            r_cnt        <= '0;
            r_dleft      <= '0;
            r_error      <= 1'b0;
        end else begin
            if (w_a_first) begin
                r_rr <= ~w_sel;
                if (w_a_extra != 5'd0) begin
                    r_lock       <= 1'b1;
                    r_lock_port  <= w_sel;
                    r_beats_left <= w_a_extra;
                end
            end else if (w_a_fire) begin
                r_beats_left <= r_beats_left - 5'd1;
                if (r_beats_left == 5'd1) r_lock <= 1'b0;
            end
            if (w_d_fire)
                r_dleft[w_d_port] <= w_d_first ? w_d_extra : r_dleft[w_d_port] - 5'd1;
            // A response for a port with nothing outstanding, unless its request fires now.
            if (w_d_fire && w_d_first && (r_cnt[w_d_port] == 4'd0) && !w_inc[w_d_port])
                r_error <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                if (w_inc[n] && !w_dec[n])
                    r_cnt[n] <= r_cnt[n] + 4'd1;
                else if (w_dec[n] && !w_inc[n] && (r_cnt[n] != 4'd0))
                    r_cnt[n] <= r_cnt[n] - 4'd1;
            end
        end
    end

    assign idle  = ~r_lock & (r_cnt[0] == 4'd0) & (r_cnt[1] == 4'd0);
    assign error = r_error;
endmodule

// File: tb/tb_tl_frag_arbiter.sv
// Bench for tl_frag_arbiter: directed scenarios plus randomized traffic against a
// message-level reference model (outstanding counts, burst remainder, rr preference).
module tb_tl_frag_arbiter;
    logic clock = 1'b0;
    logic rst_n = 1'b1;
    logic idle, error;
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_cnt[2];
    int m_drem[2];
    int m_lock_rem, m_lock_port, m_rr;
    bit m_err;

    tl_frag_arbiter_if bus();
    tl_frag_arbiter dut (.clock(clock), .reset(rst_n), .bus(bus), .idle(idle), .error(error));

    always #5 clock = ~clock;

    function automatic int beats(logic [2:0] op, logic [2:0] size);
        if (op[2] || size <= 3'd2) return 1;
        return 1 << (size - 3'd2);
    endfunction

    task automatic model_reset();
        m_cnt = '{0, 0};
        m_drem = '{0, 0};
        m_lock_rem = 0; m_lock_port = 0; m_rr = 0; m_err = 0;
    endtask

    function automatic int exp_winner();
        bit e0, e1;
        if (m_lock_rem > 0) begin
            if (m_lock_port == 0) return bus.in0_a_valid ? 0 : -1;
            return bus.in1_a_valid ? 1 : -1;
        end
        e0 = bus.in0_a_valid && (m_cnt[0] < 15);
        e1 = bus.in1_a_valid && (m_cnt[1] < 15);
        if (e0 && e1) return m_rr;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    function automatic logic [70:0] exp_a();
        int w = exp_winner();
        if (w < 0) return '0;
        if (w == 0)
            return {1'b1, bus.out_a_ready, 1'b0, 1'b0, bus.in0_a_bits_source, bus.in0_a_bits_opcode,
                    bus.in0_a_bits_param, bus.in0_a_bits_size, bus.in0_a_bits_address,
                    bus.in0_a_bits_mask, bus.in0_a_bits_data, bus.in0_a_bits_corrupt};
        return {1'b1, 1'b0, bus.out_a_ready, 1'b1, bus.in1_a_bits_source, bus.in1_a_bits_opcode,
                bus.in1_a_bits_param, bus.in1_a_bits_size, bus.in1_a_bits_address,
                bus.in1_a_bits_mask, bus.in1_a_bits_data, bus.in1_a_bits_corrupt};
    endfunction

    function automatic logic [70:0] act_a();
        if (!bus.out_a_valid) return {1'b0, bus.in0_a_ready, bus.in1_a_ready, 68'd0};
        return {bus.out_a_valid, bus.in0_a_ready, bus.in1_a_ready, bus.out_a_bits_source,
                bus.out_a_bits_opcode, bus.out_a_bits_param, bus.out_a_bits_size,
                bus.out_a_bits_address, bus.out_a_bits_mask, bus.out_a_bits_data,
                bus.out_a_bits_corrupt};
    endfunction

    function automatic logic [86:0] exp_d();
        logic        p = bus.out_d_bits_source[4];
        logic [41:0] f = {bus.out_d_bits_opcode, bus.out_d_bits_size,
                          bus.out_d_bits_source[3:0], bus.out_d_bits_data};
        return {bus.out_d_valid && !p, bus.out_d_valid && p,
                p ? bus.in1_d_ready : bus.in0_d_ready, f, f};
    endfunction

    function automatic logic [86:0] act_d();
        return {bus.in0_d_valid, bus.in1_d_valid, bus.out_d_ready,
                bus.in0_d_bits_opcode, bus.in0_d_bits_size, bus.in0_d_bits_source, bus.in0_d_bits_data,
                bus.in1_d_bits_opcode, bus.in1_d_bits_size, bus.in1_d_bits_source, bus.in1_d_bits_data};
    endfunction

    // Applies the handshakes visible this cycle to the model; call before the rising edge.
    task automatic model_update();
        int  w, p;
        int  inc[2];
        int  dec[2];
        bit  d_rdy;
        inc = '{0, 0};
        dec = '{0, 0};
        if (!rst_n) return;
        w = exp_winner();
        if (w >= 0 && bus.out_a_ready) begin
            if (m_lock_rem > 0) m_lock_rem--;
            else begin
                inc[w] = 1;
                m_rr = 1 - w;
                m_lock_port = w;
                m_lock_rem = (w == 0) ? beats(bus.in0_a_bits_opcode, bus.in0_a_bits_size) - 1
                                      : beats(bus.in1_a_bits_opcode, bus.in1_a_bits_size) - 1;
            end
        end
        p = int'(bus.out_d_bits_source[4]);
        d_rdy = p ? bus.in1_d_ready : bus.in0_d_ready;
        if (bus.out_d_valid && d_rdy) begin
            if (m_drem[p] == 0) begin
                if (m_cnt[p] == 0 && inc[p] == 0) m_err = 1;
                m_drem[p] = (bus.out_d_bits_opcode == 3'd1) ? beats(3'd1, bus.out_d_bits_size) : 1;
            end
            m_drem[p]--;
            if (m_drem[p] == 0) dec[p] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = m_cnt[i] + inc[i] - dec[i];
            if (m_cnt[i] < 0) m_cnt[i] = 0;
        end
    endtask

    task automatic advance();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int p, input bit v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [16:0] addr, input logic [31:0] data);
        if (p == 0) begin
            bus.in0_a_valid = v; bus.in0_a_bits_opcode = op; bus.in0_a_bits_size = sz;
            bus.in0_a_bits_source = src; bus.in0_a_bits_address = addr; bus.in0_a_bits_data = data;
            bus.in0_a_bits_param = 3'($urandom); bus.in0_a_bits_mask = 4'($urandom);
            bus.in0_a_bits_corrupt = 1'($urandom);
        end else begin
            bus.in1_a_valid = v; bus.in1_a_bits_opcode = op; bus.in1_a_bits_size = sz;
            bus.in1_a_bits_source = src; bus.in1_a_bits_address = addr; bus.in1_a_bits_data = data;
            bus.in1_a_bits_param = 3'($urandom); bus.in1_a_bits_mask = 4'($urandom);
            bus.in1_a_bits_corrupt = 1'($urandom);
        end
    endtask

    task automatic set_d(input bit v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [4:0] src, input logic [31:0] data);
        bus.out_d_valid = v; bus.out_d_bits_opcode = op; bus.out_d_bits_size = sz;
        bus.out_d_bits_source = src; bus.out_d_bits_data = data;
    endtask

    task automatic idle_inputs();
        set_a(0, 0, 3'd4, 3'd2, 4'd0, 17'd0, 32'd0);
        set_a(1, 0, 3'd4, 3'd2, 4'd0, 17'd0, 32'd0);
        set_d(0, 3'd0, 3'd2, 5'd0, 32'd0);
        bus.out_a_ready = 1'b1; bus.in0_d_ready = 1'b1; bus.in1_d_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_a(0, 1, 3'd4, 3'd2, 4'd5, 17'h40, 32'h1234);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (idle !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL reset_status: idle=%b error=%b expected 1/0", idle, error); end
        n_tests++; if (act_a() !== exp_a()) begin n_fail++;
            $display("FAIL reset_a_pass: got %h expected %h", act_a(), exp_a()); end
        set_d(1, 3'd0, 3'd2, 5'h13, 32'h55);
        #1;
        n_tests++; if (act_d() !== exp_d()) begin n_fail++;
            $display("FAIL reset_d_pass: got %h expected %h", act_d(), exp_d()); end
        @(posedge clock);
        #1 rst_n = 1'b1;
        idle_inputs();
        @(negedge clock);
        n_tests++; if (idle !== 1'b1) begin n_fail++;
            $display("FAIL reset_release_idle: idle=%b expected 1", idle); end
        advance();
    endtask

    task automatic test_single_get();
        do_reset();
        idle_inputs();
        set_a(0, 1, 3'd4, 3'd2, 4'd3, 17'h100, 32'h0);
        @(negedge clock);
        n_tests++; if (bus.out_a_valid !== 1'b1 || bus.out_a_bits_source !== 5'h03 ||
                       bus.out_a_bits_address !== 17'h100 || bus.in0_a_ready !== 1'b1) begin n_fail++;
            $display("FAIL single_get_a: valid=%b src=%h addr=%h rdy=%b expected 1/03/100/1",
                     bus.out_a_valid, bus.out_a_bits_source, bus.out_a_bits_address, bus.in0_a_ready); end
        advance();
        bus.in0_a_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (idle !== 1'b0) begin n_fail++;
            $display("FAIL single_get_busy: idle=%b expected 0", idle); end
        advance();
        set_d(1, 3'd1, 3'd2, 5'h03, 32'hcafe0001);
        @(negedge clock);
        n_tests++; if (bus.in0_d_valid !== 1'b1 || bus.in1_d_valid !== 1'b0 ||
                       bus.in0_d_bits_source !== 4'h3 || bus.in0_d_bits_data !== 32'hcafe0001) begin n_fail++;
            $display("FAIL single_get_d: v0=%b v1=%b src=%h data=%h expected 1/0/3/cafe0001",
                     bus.in0_d_valid, bus.in1_d_valid, bus.in0_d_bits_source, bus.in0_d_bits_data); end
        advance();
        bus.out_d_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (idle !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL single_get_done: idle=%b error=%b expected 1/0", idle, error); end
        advance();
    endtask

    task automatic test_alternate();
        do_reset();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            set_a(0, 1, 3'd4, 3'($urandom), 4'($urandom), 17'($urandom), $urandom);
            set_a(1, 1, 3'd4, 3'($urandom), 4'($urandom), 17'($urandom), $urandom);
            @(negedge clock);
            n_tests++; if (bus.out_a_valid !== 1'b1 || bus.out_a_bits_source[4] !== 1'(i % 2)) begin n_fail++;
                $display("FAIL alternate_port%0d: valid=%b port=%b expected 1/%0d",
                         i, bus.out_a_valid, bus.out_a_bits_source[4], i % 2); end
            n_tests++; if (act_a() !== exp_a()) begin n_fail++;
                $display("FAIL alternate_a%0d: got %h expected %h", i, act_a(), exp_a()); end
            advance();
        end
    endtask

    task automatic test_put_lock();
        do_reset();
        idle_inputs();
        set_a(0, 1, 3'd4, 3'd2, 4'd1, 17'h10, 32'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            set_a(1, 1, 3'd0, 3'd4, 4'd7, 17'h200, 32'h1000 + 32'(i));
            @(negedge clock);
            n_tests++; if (bus.out_a_bits_source !== 5'h17 || bus.in0_a_ready !== 1'b0 ||
                           bus.in1_a_ready !== 1'b1 || bus.out_a_bits_data !== 32'h1000 + 32'(i)) begin n_fail++;
                $display("FAIL put_lock_beat%0d: src=%h r0=%b r1=%b data=%h expected 17/0/1/%h", i,
                         bus.out_a_bits_source, bus.in0_a_ready, bus.in1_a_ready, bus.out_a_bits_data,
                         32'h1000 + 32'(i)); end
            advance();
        end
        set_a(1, 1, 3'd4, 3'd2, 4'd7, 17'h300, 32'd0);
        @(negedge clock);
        n_tests++; if (bus.out_a_bits_source[4] !== 1'b0 || bus.in0_a_ready !== 1'b1) begin n_fail++;
            $display("FAIL put_lock_release: port=%b r0=%b expected 0/1",
                     bus.out_a_bits_source[4], bus.in0_a_ready); end
        advance();
    endtask

    task automatic test_throttle();
        int bad = 0;
        do_reset();
        idle_inputs();
        set_a(0, 1, 3'd4, 3'd2, 4'd2, 17'h0, 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (bus.in0_a_ready !== 1'b1) bad++;
            advance();
        end
        n_tests++; if (bad != 0) begin n_fail++;
            $display("FAIL throttle_fill: %0d of 15 requests not accepted, expected 0", bad); end
        @(negedge clock);
        n_tests++; if (bus.out_a_valid !== 1'b0 || bus.in0_a_ready !== 1'b0) begin n_fail++;
            $display("FAIL throttle_mask: valid=%b r0=%b expected 0/0", bus.out_a_valid, bus.in0_a_ready); end
        advance();
        set_a(1, 1, 3'd4, 3'd2, 4'd9, 17'h4, 32'd0);
        @(negedge clock);
        n_tests++; if (bus.out_a_bits_source !== 5'h19 || bus.in1_a_ready !== 1'b1) begin n_fail++;
            $display("FAIL throttle_other: src=%h r1=%b expected 19/1", bus.out_a_bits_source, bus.in1_a_ready); end
        advance();
        bus.in1_a_valid = 1'b0;
        set_d(1, 3'd0, 3'd2, 5'h02, 32'd0);
        @(negedge clock);
        n_tests++; if (bus.out_a_valid !== 1'b0) begin n_fail++;
            $display("FAIL throttle_still: valid=%b expected 0", bus.out_a_valid); end
        advance();
        bus.out_d_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (bus.out_a_valid !== 1'b1 || bus.out_a_bits_source !== 5'h02) begin n_fail++;
            $display("FAIL throttle_reenable: valid=%b src=%h expected 1/02", bus.out_a_valid, bus.out_a_bits_source); end
        advance();
    endtask

    task automatic test_error();
        do_reset();
        idle_inputs();
        set_d(1, 3'd0, 3'd2, 5'h12, 32'hdead);
        @(negedge clock);
        n_tests++; if (bus.in1_d_valid !== 1'b1 || bus.in0_d_valid !== 1'b0 || error !== 1'b0) begin n_fail++;
            $display("FAIL error_route: v1=%b v0=%b err=%b expected 1/0/0", bus.in1_d_valid, bus.in0_d_valid, error); end
        advance();
        bus.out_d_valid = 1'b0;
        repeat (3) advance();
        @(negedge clock);
        n_tests++; if (error !== 1'b1 || idle !== 1'b1) begin n_fail++;
            $display("FAIL error_sticky: err=%b idle=%b expected 1/1", error, idle); end
        set_a(1, 1, 3'd4, 3'd2, 4'd0, 17'h8, 32'd0);
        advance();
        bus.in1_a_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (idle !== 1'b0) begin n_fail++;
            $display("FAIL error_no_underflow: idle=%b expected 0", idle); end
        advance();
        set_d(1, 3'd0, 3'd2, 5'h10, 32'd0);
        advance();
        bus.out_d_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (idle !== 1'b1 || error !== 1'b1) begin n_fail++;
            $display("FAIL error_recover: idle=%b err=%b expected 1/1", idle, error); end
        advance();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        idle_inputs();
        set_a(1, 1, 3'd0, 3'd5, 4'd4, 17'h400, 32'h1);
        advance();
        set_a(1, 1, 3'd0, 3'd5, 4'd4, 17'h400, 32'h2);
        @(negedge clock);
        #2 rst_n = 1'b0;
        model_reset();
        set_a(0, 1, 3'd4, 3'd2, 4'd6, 17'h20, 32'd0);
        #1;
        n_tests++; if (idle !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL midburst_reset_now: idle=%b err=%b expected 1/0", idle, error); end
        n_tests++; if (act_a() !== exp_a()) begin n_fail++;
            $display("FAIL midburst_in_reset: got %h expected %h", act_a(), exp_a()); end
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        n_tests++; if (idle !== 1'b1 || bus.out_a_bits_source !== 5'h06 || bus.in1_a_ready !== 1'b0) begin n_fail++;
            $display("FAIL midburst_after: idle=%b src=%h r1=%b expected 1/06/0",
                     idle, bus.out_a_bits_source, bus.in1_a_ready); end
        advance();
    endtask

    task automatic test_random();
        int bad_a = 0, bad_d = 0, bad_s = 0;
        logic [2:0] ops [3];
        ops = '{3'd0, 3'd1, 3'd4};
        do_reset();
        idle_inputs();
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 2; p++)
                set_a(p, $urandom_range(0, 99) < 60, ops[$urandom_range(0, 2)],
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                      4'($urandom), 17'($urandom), $urandom);
            set_d($urandom_range(0, 99) < 50, $urandom_range(0, 1) ? 3'd1 : 3'd0,
                  3'($urandom_range(0, 4)), 5'($urandom), $urandom);
            bus.out_a_ready = $urandom_range(0, 99) < 75;
            bus.in0_d_ready = $urandom_range(0, 99) < 70;
            bus.in1_d_ready = $urandom_range(0, 99) < 70;
            @(negedge clock);
            n_tests++; if (act_a() !== exp_a()) begin n_fail++; bad_a++;
                if (bad_a < 5) $display("FAIL random_a c%0d: got %h expected %h", c, act_a(), exp_a()); end
            n_tests++; if (act_d() !== exp_d()) begin n_fail++; bad_d++;
                if (bad_d < 5) $display("FAIL random_d c%0d: got %h expected %h", c, act_d(), exp_d()); end
            n_tests++; if (idle !== (m_lock_rem == 0 && m_cnt[0] == 0 && m_cnt[1] == 0) || error !== m_err) begin
                n_fail++; bad_s++;
                if (bad_s < 5) $display("FAIL random_status c%0d: idle=%b err=%b expected %b/%b", c, idle, error,
                                        (m_lock_rem == 0 && m_cnt[0] == 0 && m_cnt[1] == 0), m_err); end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_get();
        test_alternate();
        test_put_lock();
        test_throttle();
        test_error();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
